// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader: words stream into a shadow bank and are
// copied to the active bank (driving the mac) in a single cycle on commit.
module fir_coef_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    localparam int CW        = $clog2(NUM_REGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         loadStart,
    input  logic signed [DATA_WIDTH-1:0] coefIn,
    input  logic                         coefValid,
    output logic                         coefReady,
    input  logic                         commit,
    output logic signed [DATA_WIDTH-1:0] coefs [0:NUM_REGS-1],
    output logic        [CW-1:0]         coefCount,
    output logic                         loadDone,
    output logic                         coefsUpdated,
    output logic                         loadError
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StFull = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_d;
    logic        [CW-1:0]         r_count;
    logic        [CW-1:0]         w_count_d;
    logic                         r_err;
    logic                         w_err_d;
    logic                         r_updated;
    logic                         w_wr;
    logic                         w_commit;
    logic signed [DATA_WIDTH-1:0] r_shadow [0:NUM_REGS-1];
    logic signed [DATA_WIDTH-1:0] r_coefs  [0:NUM_REGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_updated <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_count   <= w_count_d;
            r_err     <= w_err_d;
            r_updated <= w_commit;
        end
    end

    // loadStart overrides any transfer or commit in the same cycle.
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_err_d   = r_err;
        w_wr      = 1'b0;
        w_commit  = 1'b0;
        if (loadStart) begin
            w_state_d = StLoad;
            w_count_d = '0;
            w_err_d   = 1'b0;
        end else begin
            if (commit && (r_state != StFull)) begin
                w_err_d = 1'b1;
            end
            case (r_state)
                StLoad: begin
                    if (coefValid) begin
                        w_wr      = 1'b1;
                        w_count_d = r_count + CW'(1);
                        if (r_count == CW'(NUM_REGS - 1)) begin
                            w_state_d = StFull;
                        end
                    end
                end
                StFull: begin
                    if (commit) begin
                        w_commit  = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
                r_coefs[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr && (r_count == CW'(i))) begin
                    r_shadow[i] <= coefIn;
                end
                if (w_commit) begin
                    r_coefs[i] <= r_shadow[i];
                end
            end
        end
    end

    assign coefs        = r_coefs;
    assign coefCount    = r_count;
    assign coefReady    = (r_state == StLoad);
    assign loadDone     = (r_state == StFull);
    assign coefsUpdated = r_updated;
    assign loadError    = r_err;

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Sequential front end that writes the FIR coefficient set consumed by the mac block.
- Accepts coefficients one at a time over a valid/ready stream into a shadow bank.
- On commit, copies the shadow bank to the active bank in one cycle. The active bank drives the mac coefs input directly, so taps never see a partially loaded set.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (constants.svh): coefficient width, signed, same Q format as mac (Q_FORMAT = DATA_WIDTH/2).
- NUM_REGS, `NUM_REGS (constants.svh): number of taps/coefficients; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- loadStart  in  1  single-cycle pulse; begins a new load at index 0.
- coefIn  in  DATA_WIDTH signed  coefficient data.
- coefValid  in  1  coefIn valid.
- coefReady  out  1  loader accepts coefIn this cycle.
- commit  in  1  single-cycle pulse; transfer shadow to active.
- coefs  out  DATA_WIDTH signed x [0:NUM_REGS-1]  active bank to mac.coefs.
- coefCount  out  $clog2(NUM_REGS+1)  number of coefficients accepted in the current load.
- loadDone  out  1  high while a complete shadow set awaits commit.
- coefsUpdated  out  1  one-cycle pulse; active bank changed.
- loadError  out  1  sticky protocol error flag.

Behaviour:
- Reset (async assert, sync release on clk):
  - state=IDLE; coefs all 0; shadow all 0; coefCount=0.
  - coefReady, loadDone, coefsUpdated and loadError all 0.
- All outputs are registered. coefReady is decoded from state only and does not depend on coefValid.
- A transfer occurs on the rising edge where coefValid && coefReady.
- States:
  - IDLE: coefReady=0; loadDone=0.
    - loadStart: go to LOAD; coefCount=0; loadError cleared.
  - LOAD: coefReady=1.
    - On each transfer: shadow[coefCount] <= coefIn; coefCount++.
    - On the transfer that makes coefCount==NUM_REGS: go to FULL.
  - FULL: coefReady=0; loadDone=1.
    - commit: coefs[i] <= shadow[i] for all i; coefsUpdated=1 in the next cycle; go to IDLE.
    - coefCount holds NUM_REGS until the next loadStart.
- Coefficient order: the first accepted word is coefs[0], the tap that multiplies pDataIn[0].
- Commit latency: commit sampled at edge N makes new coefs visible after edge N. coefsUpdated is high for exactly the cycle following edge N.
- loadStart in LOAD or FULL:
  - Restart the load: coefCount=0, go to LOAD, loadError cleared.
  - The shadow bank is overwritten progressively. The active bank is untouched.
- loadStart and coefValid together while in LOAD: loadStart wins and the data word is not written. coefReady stays 1.
- loadStart and commit in the same cycle: loadStart wins, commit is ignored, no error.
- commit while in IDLE or LOAD:
  - loadError <= 1, sticky until the next loadStart or rst.
  - Active bank unchanged; state unchanged.
- coefValid while coefReady=0: ignored, no error. Data is dropped and the upstream source must hold it.
- Data is stored bit-exact, with no rounding or saturation. Width conversion is the upstream source's responsibility.
- A reset asserted mid-load or mid-commit returns the active bank to all 0. mac output is then 0 until the next commit.

Test Plan (DATA_WIDTH=16, NUM_REGS=4):
- Basic load: rst, then loadStart, then words 0x0100, 0x0080, 0xFF80, 0x0040 with coefValid held high -> 4 consecutive transfers; loadDone=1 after the 4th. After commit, coefs={0x0100,0x0080,0xFF80,0x0040} one cycle later, with a single coefsUpdated pulse.
- Backpressure/stall: toggle coefValid randomly during load -> only valid&&ready edges write. coefCount steps 0..4. coefValid asserted in FULL is ignored and the shadow is unchanged.
- Double buffering: with the active bank loaded, run a second load of 0x7FFF×4 with no commit -> coefs unchanged throughout. After commit -> all 0x7FFF.
- Early commit: loadStart, 2 words, commit -> loadError=1 and held; coefs unchanged; state still LOAD. Then loadStart -> loadError=0 and coefCount=0.
- Priority: in FULL, assert loadStart and commit together -> no coefsUpdated; state LOAD; coefCount=0; coefs unchanged.
- Reset mid-operation: assert rst asynchronously (between clock edges) after 3 words of a load over committed nonzero coefs -> coefs all 0, coefReady=0, coefCount=0 immediately, before the next clock edge.
